// File: rtl/run_ctrl.sv
// Program run sequencer: turns the host Start/Ack handshake into core reset, PC preload,
// run enable and halt/watchdog detection, and keeps the per-run cycle counter.
module run_ctrl #(
  parameter int PC_W    = 10,
  parameter int CT_W    = 16,
  parameter int CLR_CYC = 2,
  parameter int TIMEOUT = 1000
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic [PC_W-1:0] ProgBase,
  input  logic            HaltOp,
  output logic            CoreRst,
  output logic            PcLoad,
  output logic [PC_W-1:0] PcInit,
  output logic            RunEn,
  output logic            Busy,
  output logic            Ack,
  output logic            TimedOut,
  output logic [CT_W-1:0] CycleCt
);

  localparam int              CLR_W    = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYC - 1);
  localparam logic [CT_W-1:0]  CT_LAST  = CT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic              start_d_reg;
  logic [CLR_W-1:0]  clr_cnt_reg, clr_cnt_next;
  logic [CT_W-1:0]   cycle_ct_reg, cycle_ct_next;
  logic [PC_W-1:0]   pc_init_reg, pc_init_next;
  logic              timed_out_reg, timed_out_next;
  logic              start_edge;

  // start_d clears on reset, so a Start already high at release is seen as an edge
  assign start_edge = Start & ~start_d_reg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg     <= IDLE;
      start_d_reg   <= 1'b0;
      clr_cnt_reg   <= '0;
      cycle_ct_reg  <= '0;
      pc_init_reg   <= '0;
      timed_out_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      start_d_reg   <= Start;
      clr_cnt_reg   <= clr_cnt_next;
      cycle_ct_reg  <= cycle_ct_next;
      pc_init_reg   <= pc_init_next;
      timed_out_reg <= timed_out_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    clr_cnt_next   = clr_cnt_reg;
    cycle_ct_next  = cycle_ct_reg;
    pc_init_next   = pc_init_reg;
    timed_out_next = timed_out_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start_edge) begin
          state_next     = CLEAR;
          pc_init_next   = ProgBase;
          cycle_ct_next  = '0;
          timed_out_next = 1'b0;
          clr_cnt_next   = '0;
        end
      end
      CLEAR: begin
        clr_cnt_next = clr_cnt_reg + CLR_W'(1);
        if (clr_cnt_reg == CLR_LAST) begin
          state_next = RUN;
        end
      end
      RUN: begin
        cycle_ct_next = cycle_ct_reg + CT_W'(1);
        // Halt beats both abort and watchdog; an abort restarts the run from CLEAR
        if (HaltOp) begin
          state_next = DONE;
        end else if (start_edge) begin
          state_next    = CLEAR;
          pc_init_next  = ProgBase;
          cycle_ct_next = '0;
          clr_cnt_next  = '0;
        end else if (cycle_ct_reg == CT_LAST) begin
          state_next     = DONE;
          timed_out_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign CoreRst  = (state_reg == IDLE) || (state_reg == CLEAR);
  assign PcLoad   = (state_reg == CLEAR);
  assign RunEn    = (state_reg == RUN);
  assign Busy     = (state_reg == CLEAR) || (state_reg == RUN);
  assign Ack      = (state_reg == DONE);
  assign PcInit   = pc_init_reg;
  assign TimedOut = timed_out_reg;
  assign CycleCt  = cycle_ct_reg;

endmodule
